// File: rtl/drill_bist_pkg.sv
// Shared types and constants for the drill self-test engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package drill_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DEF_POLY   = 8'h07;
    localparam logic [7:0] DEF_GOLDEN = 8'h3F;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/drill_sisr.sv
// Serial-input signature register: one CRC shift per enabled cycle, synchronous clear.
// Latency: signature reflects din one cycle after en.
// Backpressure: none; clr wins over en.
module drill_sisr #(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = 8'h07
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             fb;

    always_comb begin
        fb    = sig_q[SIG_W-1] ^ din;
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/drill_bist.sv
// drill_bist_ctrl: exhaustive-vector BIST driver/checker with CRC compaction; DRILL_BIST_EXPECT_EN adds per-vector compare.
// Latency: done pulses 2^N_IN*(SETTLE+1) cycles after the start-accept edge.
// Backpressure: start is only honoured in IDLE; all other starts are dropped.
module drill_bist_ctrl
    import drill_bist_pkg::*;
#(
    parameter int                    N_IN   = 3,
    parameter int                    SETTLE = 1,
    parameter int                    SIG_W  = 8,
    parameter logic [SIG_W-1:0]      POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0]      GOLDEN = DEF_GOLDEN,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = 8'h90
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN-1:0]  fail_idx,
    output logic             fail_any
);

    localparam int              CW          = (clog2(SETTLE + 1) < 1) ? 1 : clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN-1:0]   fail_idx_q, fail_idx_d;
    logic              fail_any_q, fail_any_d;
    logic              sisr_clr, sisr_en;
    logic [SIG_W-1:0]  sig_w;
    logic [SIG_W-1:0]  sig_next;
    logic              fb;

    drill_sisr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sisr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sisr_clr),
        .en    (sisr_en),
        .din   (dut_out),
        .sig   (sig_w)
    );

    // Signature after the final capture, so pass is valid in the same cycle as done.
    always_comb begin
        fb       = sig_w[SIG_W-1] ^ dut_out;
        sig_next = {sig_w[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        fail_any_d = fail_any_q;
        sisr_clr   = 1'b0;
        sisr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sisr_clr   = 1'b1;
                    pass_d     = 1'b0;
                    fail_idx_d = '0;
                    fail_any_d = 1'b0;
                    dut_in_d   = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                sisr_en = 1'b1;
`ifdef DRILL_BIST_EXPECT_EN
                if (!fail_any_q && (dut_out != EXPECT[dut_in_q])) begin
                    fail_any_d = 1'b1;
                    fail_idx_d = dut_in_q;
                end
`endif
                if (dut_in_q == LAST_VEC) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (sig_next == GOLDEN) && !fail_any_d;
                    state_d = S_DONE;
                end else begin
                    dut_in_d = dut_in_q + 1'b1;
                    state_d  = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            fail_any_q <= fail_any_d;
        end
    end

`ifndef DRILL_BIST_EXPECT_EN
    // Per-vector expectations only matter when the compare feature is built in.
    logic unused_expect;
    assign unused_expect = ^EXPECT;
`endif

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_w;
    assign fail_idx  = fail_idx_q;
    assign fail_any  = fail_any_q;

endmodule

// File: tb/tb_drill_bist_ctrl.sv
// Bench for drill_bist_ctrl: SETTLE=1 and SETTLE=3 instances driven by table-defined drill circuits.
module tb_drill_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] tbl_a, tbl_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] sig_a, sig_b;
    logic [2:0] fidx_a, fidx_b;
    logic       fany_a, fany_b;

    int checks = 0;
    int errors = 0;

    assign dut_out_a = tbl_a[dut_in_a];
    assign dut_out_b = tbl_b[dut_in_b];

    drill_bist_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
        .fail_idx(fidx_a), .fail_any(fany_a)
    );

    drill_bist_ctrl #(.SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
        .fail_idx(fidx_b), .fail_any(fany_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signature = M(x)*x^8 mod (x^8+x^2+x+1), first vector = highest-degree bit.
    function automatic logic [7:0] crc_ref(input logic [7:0] tbl);
        logic [15:0] rem;
        rem = 16'h0;
        for (int v = 0; v < 8; v++) rem[15 - v] = tbl[v];
        for (int b = 15; b >= 8; b--)
            if (rem[b]) rem = rem ^ (16'h0107 << (b - 8));
        return rem[7:0];
    endfunction

    task automatic run(input int which, input logic [7:0] tbl, input int poke_k, input string tag);
        int         s1;
        int         k;
        logic [7:0] exp_sig;
        logic [7:0] expv;
        logic       mis;
        logic [2:0] mis_idx;
        logic       exp_fa;
        logic [2:0] exp_fi;
        logic       exp_pass;
        s1      = (which != 0) ? 4 : 2;
        exp_sig = crc_ref(tbl);
        expv    = 8'h90;
        mis     = 1'b0;
        mis_idx = 3'd0;
        for (int v = 0; v < 8; v++)
            if (!mis && (tbl[v] != expv[v])) begin
                mis     = 1'b1;
                mis_idx = 3'(v);
            end
`ifdef DRILL_BIST_EXPECT_EN
        exp_fa   = mis;
        exp_fi   = mis_idx;
        exp_pass = (exp_sig == 8'h3F) && !mis;
`else
        exp_fa   = 1'b0;
        exp_fi   = 3'd0;
        exp_pass = (exp_sig == 8'h3F);
`endif
        if (which != 0) tbl_b = tbl; else tbl_a = tbl;
        @(negedge clk);
        if (which != 0) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        k = 0;
        chk({tag, "_busy_start"}, (which != 0) ? busy_b : busy_a, 1);
        while (!((which != 0) ? done_b : done_a) && k < 200) begin
            if (which != 0) start_b = (k == poke_k); else start_a = (k == poke_k);
            chk({tag, "_dut_in_step"}, (which != 0) ? dut_in_b : dut_in_a, 32'(k / s1));
            @(negedge clk);
            k++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_done_latency"}, k, 8 * s1);
        chk({tag, "_signature"}, (which != 0) ? sig_b : sig_a, exp_sig);
        chk({tag, "_pass"}, (which != 0) ? pass_b : pass_a, exp_pass);
        chk({tag, "_busy_done"}, (which != 0) ? busy_b : busy_a, 0);
        chk({tag, "_dut_in_hold"}, (which != 0) ? dut_in_b : dut_in_a, 7);
        chk({tag, "_fail_any"}, (which != 0) ? fany_b : fany_a, exp_fa);
        chk({tag, "_fail_idx"}, (which != 0) ? fidx_b : fidx_a, exp_fi);
        @(negedge clk);
        chk({tag, "_done_pulse"}, (which != 0) ? done_b : done_a, 0);
        chk({tag, "_pass_held"}, (which != 0) ? pass_b : pass_a, exp_pass);
        chk({tag, "_sig_held"}, (which != 0) ? sig_b : sig_a, exp_sig);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tbl_a   = 8'h90;
        tbl_b   = 8'h90;
        repeat (3) @(negedge clk);
        chk("rst_busy", {busy_a, busy_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_pass", {pass_a, pass_b}, 0);
        chk("rst_sig", {sig_a, sig_b}, 0);
        chk("rst_dut_in", {dut_in_a, dut_in_b}, 0);
        chk("rst_fail", {fany_a, fidx_a, fany_b, fidx_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 8'h90, -1, "correct");
        run(0, 8'h00, -1, "stuck0");
        run(0, 8'hFF, -1, "stuck1");
        run(1, 8'h90, 5, "settle3_poke");
        run(0, 8'h80, -1, "inv_v4");

        // Abort mid-run with a stuck-at-1 circuit so the signature is non-zero when reset hits.
        tbl_a = 8'hFF;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrun_busy_before", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_sig", sig_a, 0);
        chk("abort_dut_in", dut_in_a, 0);
        chk("abort_fail", {fany_a, fidx_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 8'h90, -1, "rerun");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] t;
            int         w;
            t = 8'($urandom);
            w = $urandom_range(0, 1);
            run(w, t, -1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
